// File: rtl/fu_pkg.sv
// Shared definitions for the functional-unit wrappers.
//   - Default operand/result and tag widths used by every FU wrapper.
//   - Issue controller FSM state encoding (2-bit) and its enum type.
package fu_pkg;

  localparam int FU_DATA_WIDTH = 32;
  localparam int FU_TAG_WIDTH  = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_WB    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_WB    = ST_WB
  } fu_state_e;

endpackage : fu_pkg

// File: rtl/fu_op_fifo.sv
// Operation FIFO for the FU issue controller: DEPTH entries of WIDTH bits.
// Ports:
//   clk, rst     clock, synchronous active-high reset (empties the FIFO)
//   push         write push_data (ignored when full)
//   push_data    entry to write
//   pop          drop the head entry (ignored when empty)
//   head_data    current head entry (valid when not empty)
//   full, empty  occupancy flags
//   count        number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module fu_op_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0] CNT_ONE = (PTR_W + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // A push is refused while full even if a pop happens in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10: begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        count_d  = count_q + CNT_ONE;
      end
      2'b01: begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        count_d  = count_q - CNT_ONE;
      end
      2'b11: begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule : fu_op_fifo

// File: rtl/fu_issue_ctrl.sv
// Initiator side of the FU handshake: queues tagged operand pairs, issues
// them one at a time to a single FU and returns each result with its tag on
// a valid/ready writeback port, in dispatch order.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            dispatch handshake (in_ready = FIFO not full)
//   in_data_0/1, in_tag          operands and destination tag
//   fu_ce                        one-cycle issue strobe to the FU
//   fu_data_0/1                  operands to the FU (FIFO head)
//   fu_idle                      FU can accept an operation
//   fu_done, fu_result           FU completion and its result
//   wb_valid/wb_ready            writeback handshake
//   wb_result, wb_tag            captured result and its tag
//   busy                         work queued or in flight
module fu_issue_ctrl
  import fu_pkg::*;
#(
  parameter int DATA_WIDTH = FU_DATA_WIDTH,
  parameter int TAG_WIDTH  = FU_TAG_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data_0,
  input  logic [DATA_WIDTH-1:0] in_data_1,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  fu_ce,
  output logic [DATA_WIDTH-1:0] fu_data_0,
  output logic [DATA_WIDTH-1:0] fu_data_1,
  input  logic                  fu_idle,
  input  logic [DATA_WIDTH-1:0] fu_result,
  input  logic                  fu_done,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [DATA_WIDTH-1:0] wb_result,
  output logic [TAG_WIDTH-1:0]  wb_tag,
  output logic                  busy
);

  localparam int ENTRY_W = 2 * DATA_WIDTH + TAG_WIDTH;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic [ENTRY_W-1:0]    push_entry;
  logic [ENTRY_W-1:0]    head_entry;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [TAG_WIDTH-1:0]  head_tag;
  logic                  issue_ok;

  fu_state_e             state_q, state_d;
  logic                  fu_ce_q, fu_ce_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [DATA_WIDTH-1:0] wb_result_q, wb_result_d;
  logic [TAG_WIDTH-1:0]  wb_tag_q, wb_tag_d;

  assign push_entry = {in_tag, in_data_1, in_data_0};
  assign fifo_push  = in_valid & in_ready;
  assign fifo_pop   = (state_q == S_ISSUE);

  fu_op_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign fu_data_0 = head_entry[DATA_WIDTH-1:0];
  assign fu_data_1 = head_entry[2*DATA_WIDTH-1:DATA_WIDTH];
  assign head_tag  = head_entry[ENTRY_W-1:2*DATA_WIDTH];

  assign issue_ok  = ~fifo_empty & fu_idle;

  assign in_ready  = ~fifo_full;
  assign busy      = (fifo_count != '0) | (state_q != S_IDLE);
  assign fu_ce     = fu_ce_q;
  assign wb_valid  = wb_valid_q;
  assign wb_result = wb_result_q;
  assign wb_tag    = wb_tag_q;

  // Next-state and output-register values. fu_done is only looked at in
  // WAIT: an idle FU is allowed to leave its done flag high.
  always_comb begin
    state_d     = state_q;
    fu_ce_d     = 1'b0;
    tag_d       = tag_q;
    wb_valid_d  = wb_valid_q;
    wb_result_d = wb_result_q;
    wb_tag_d    = wb_tag_q;
    case (state_q)
      S_IDLE: begin
        if (issue_ok) begin
          state_d = S_ISSUE;
          fu_ce_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        // Head pops this cycle, so its tag must be kept for the writeback.
        tag_d   = head_tag;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (fu_done) begin
          wb_result_d = fu_result;
          wb_tag_d    = tag_q;
          wb_valid_d  = 1'b1;
          state_d     = S_WB;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WB: begin
        if (wb_ready) begin
          wb_valid_d = 1'b0;
          // Go straight back to ISSUE when more work is ready.
          if (issue_ok) begin
            state_d = S_ISSUE;
            fu_ce_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_WB;
        end
      end
      default: begin
        state_d    = S_IDLE;
        wb_valid_d = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs; reset drops any in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fu_ce_q     <= 1'b0;
      tag_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_result_q <= '0;
      wb_tag_q    <= '0;
    end else begin
      state_q     <= state_d;
      fu_ce_q     <= fu_ce_d;
      tag_q       <= tag_d;
      wb_valid_q  <= wb_valid_d;
      wb_result_q <= wb_result_d;
      wb_tag_q    <= wb_tag_d;
    end
  end

endmodule : fu_issue_ctrl

// File: tb/tb_fu_issue_ctrl.sv
// Directed testbench for fu_issue_ctrl with a behavioural adder FU of
// programmable latency.
module tb_fu_issue_ctrl;

  localparam int DW    = 32;
  localparam int TW    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data_0, in_data_1;
  logic [TW-1:0] in_tag;
  logic          fu_ce;
  logic [DW-1:0] fu_data_0, fu_data_1;
  logic          fu_idle;
  logic [DW-1:0] fu_result;
  logic          fu_done;
  logic          wb_valid;
  logic          wb_ready;
  logic [DW-1:0] wb_result;
  logic [TW-1:0] wb_tag;
  logic          busy;

  int checks = 0;
  int fails  = 0;

  // FU model controls
  int            fu_lat;
  int            fu_cnt;
  logic          fu_done_m;
  logic [DW-1:0] fu_res_q, fu_acc_q;
  logic          fu_hold;
  logic          stale;

  logic [DW-1:0] pend_a[$], pend_b[$], exp_r[$];
  logic [TW-1:0] pend_t[$], exp_t[$];

  always #5 clk = ~clk;

  fu_issue_ctrl #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data_0 (in_data_0),
    .in_data_1 (in_data_1),
    .in_tag    (in_tag),
    .fu_ce     (fu_ce),
    .fu_data_0 (fu_data_0),
    .fu_data_1 (fu_data_1),
    .fu_idle   (fu_idle),
    .fu_result (fu_result),
    .fu_done   (fu_done),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_result (wb_result),
    .wb_tag    (wb_tag),
    .busy      (busy)
  );

  // Adder FU: done is high fu_lat cycles after the cycle fu_ce was high.
  always @(posedge clk) begin
    if (rst) begin
      fu_cnt    <= 0;
      fu_done_m <= 1'b0;
      fu_res_q  <= '0;
      fu_acc_q  <= '0;
    end else begin
      fu_done_m <= 1'b0;
      if (fu_ce) begin
        if (fu_lat <= 1) begin
          fu_done_m <= 1'b1;
          fu_res_q  <= fu_data_0 + fu_data_1;
        end else begin
          fu_cnt   <= fu_lat - 1;
          fu_acc_q <= fu_data_0 + fu_data_1;
        end
      end else if (fu_cnt == 1) begin
        fu_cnt    <= 0;
        fu_done_m <= 1'b1;
        fu_res_q  <= fu_acc_q;
      end else if (fu_cnt > 1) begin
        fu_cnt <= fu_cnt - 1;
      end
    end
  end

  assign fu_idle   = !fu_hold && (fu_cnt == 0);
  assign fu_done   = fu_done_m | stale;
  assign fu_result = stale ? 32'hDEAD_BEEF : fu_res_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [TW-1:0] t, input logic [DW-1:0] r);
    pend_a.push_back(a);
    pend_b.push_back(b);
    pend_t.push_back(t);
    exp_r.push_back(r);
    exp_t.push_back(t);
  endfunction

  task automatic drive_head();
    in_valid  = 1'b1;
    in_data_0 = pend_a[0];
    in_data_1 = pend_b[0];
    in_tag    = pend_t[0];
  endtask

  task automatic drop_head();
    void'(pend_a.pop_front());
    void'(pend_b.pop_front());
    void'(pend_t.pop_front());
  endtask

  // Push all pending ops and collect all expected results, in order.
  task automatic drain(input bit rand_ready, input int budget);
    int cyc = 0;
    while ((pend_a.size() != 0 || exp_r.size() != 0) && cyc < budget) begin
      logic          acc, wbx;
      logic [DW-1:0] r;
      logic [TW-1:0] t;
      if (pend_a.size() != 0) drive_head();
      else in_valid = 1'b0;
      wb_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = in_valid & in_ready;
      wbx = wb_valid & wb_ready;
      r   = wb_result;
      t   = wb_tag;
      step();
      if (acc) drop_head();
      if (wbx) begin
        if (exp_r.size() == 0) begin
          chk("wb_unexpected", 32'(exp_r.size()), 32'd1);
        end else begin
          chk("wb_result", r, exp_r[0]);
          chk("wb_tag", 32'(t), 32'(exp_t[0]));
          void'(exp_r.pop_front());
          void'(exp_t.pop_front());
        end
      end
      cyc++;
    end
    in_valid = 1'b0;
    wb_ready = 1'b1;
    chk("drain_left", 32'(pend_a.size() + exp_r.size()), 32'd0);
  endtask

  task automatic wait_wb(input int budget);
    for (int i = 0; i < budget && !wb_valid; i++) step();
    chk("wb_wait", 32'(wb_valid), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data_0 = '0; in_data_1 = '0; in_tag = '0;
    wb_ready = 1'b1; fu_lat = 1; fu_hold = 1'b0; stale = 1'b0;

    // Reset state
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fu_ce", 32'(fu_ce), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_result", wb_result, 32'd0);
    chk("rst_wb_tag", 32'(wb_tag), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Single op with exact latency
    in_valid = 1'b1; in_data_0 = 32'd7; in_data_1 = 32'd5; in_tag = 4'd3;
    step();
    in_valid = 1'b0;
    chk("single_idle_ce", 32'(fu_ce), 32'd0);
    chk("single_busy", 32'(busy), 32'd1);
    step();
    chk("single_ce", 32'(fu_ce), 32'd1);
    chk("single_d0", fu_data_0, 32'd7);
    chk("single_d1", fu_data_1, 32'd5);
    step();
    chk("single_ce_pulse", 32'(fu_ce), 32'd0);
    chk("single_wait_wbv", 32'(wb_valid), 32'd0);
    step();
    chk("single_wbv", 32'(wb_valid), 32'd1);
    chk("single_result", wb_result, 32'd12);
    chk("single_tag", 32'(wb_tag), 32'd3);
    step();
    chk("single_wbv_drop", 32'(wb_valid), 32'd0);
    chk("single_busy_end", 32'(busy), 32'd0);

    // FIFO fill while the FU is busy
    fu_lat = 3; fu_hold = 1'b1;
    add_op(32'd10, 32'd1, 4'd1, 32'd11);
    add_op(32'd20, 32'd2, 4'd2, 32'd22);
    add_op(32'd30, 32'd3, 4'd4, 32'd33);
    add_op(32'd40, 32'd4, 4'd8, 32'd44);
    add_op(32'd50, 32'd5, 4'd15, 32'd55);
    for (int i = 0; i < 4; i++) begin
      drive_head();
      chk("fill_in_ready", 32'(in_ready), 32'd1);
      step();
      drop_head();
    end
    chk("fill_full", 32'(in_ready), 32'd0);
    drive_head();
    step();
    step();
    chk("fill_still_full", 32'(in_ready), 32'd0);
    chk("fill_no_issue", 32'(fu_ce), 32'd0);
    fu_hold = 1'b0;
    drain(1'b0, 200);

    // Writeback stall with a second op queued
    fu_lat = 1; wb_ready = 1'b0;
    add_op(32'hFFFF_FFFF, 32'd1, 4'd6, 32'd0);
    add_op(32'd20, 32'd22, 4'd7, 32'd42);
    for (int i = 0; i < 2; i++) begin
      drive_head();
      step();
      drop_head();
    end
    in_valid = 1'b0;
    wait_wb(20);
    for (int i = 0; i < 10; i++) begin
      chk("stall_wbv", 32'(wb_valid), 32'd1);
      chk("stall_result", wb_result, exp_r[0]);
      chk("stall_tag", 32'(wb_tag), 32'(exp_t[0]));
      chk("stall_no_ce", 32'(fu_ce), 32'd0);
      step();
    end
    wb_ready = 1'b1;
    void'(exp_r.pop_front());
    void'(exp_t.pop_front());
    step();
    chk("fast_path_ce", 32'(fu_ce), 32'd1);
    chk("fast_path_d0", fu_data_0, 32'd20);
    drain(1'b0, 50);

    // Stale done while idle and empty
    stale = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("stale_wbv", 32'(wb_valid), 32'd0);
    end
    chk("stale_busy", 32'(busy), 32'd0);
    stale = 1'b0;
    add_op(32'd100, 32'd23, 4'd11, 32'd123);
    drain(1'b0, 50);

    // Reset while waiting on the FU with two ops queued
    fu_lat = 8;
    add_op(32'd1, 32'd1, 4'd1, 32'd2);
    add_op(32'd2, 32'd2, 4'd2, 32'd4);
    add_op(32'd3, 32'd3, 4'd3, 32'd6);
    for (int i = 0; i < 3; i++) begin
      drive_head();
      step();
      drop_head();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_wbv", 32'(wb_valid), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_wbv", 32'(wb_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_result", wb_result, 32'd0);
    chk("mid_rst_tag", 32'(wb_tag), 32'd0);
    exp_r.delete();
    exp_t.delete();
    fu_lat = 1;
    add_op(32'd1, 32'd2, 4'd9, 32'd3);
    drain(1'b0, 50);

    // Wrap-around: 3*DEPTH ops with random writeback backpressure
    fu_lat = 2;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      add_op(32'(1000 + 3 * i), 32'(7 * i), 4'(i + 2), 32'(1000 + 10 * i));
    end
    drain(1'b1, 2000);
    step();
    chk("end_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule : tb_fu_issue_ctrl
